// File: rtl/wb_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_master_ctrl                                                  |
// | Purpose  : Single-outstanding Wishbone B4 pipelined initiator. Takes one   |
// |            read/write command on a valid/ready port, runs one Wishbone     |
// |            cycle (with retry on rty and an optional timeout) and returns   |
// |            read data plus a 2-bit status on a valid/ready response port.   |
// | Ports    : clk_i, rst_n_i (sync, active-low)                               |
// |            cmd_valid_i/cmd_ready_o, cmd_we_i, cmd_adr_i, cmd_dat_i,        |
// |            cmd_sel_i                      - command channel                |
// |            rsp_valid_o/rsp_ready_i, rsp_dat_o, rsp_status_o                |
// |                                           - response channel               |
// |            wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o       |
// |            wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i              |
// |                                           - Wishbone master side           |
// | Status   : 00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT                   |
// | Config   : define WB_MASTER_TIMEOUT_EN to build the per-attempt timeout    |
// |            counter (TIMEOUT_CYCLES); otherwise the master waits forever.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_master_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RETRY_MAX      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [31:0]           cmd_dat_i,
  input  logic [3:0]            cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  // A zero RETRY_MAX still needs a 1-bit counter so the compare stays legal.
  localparam int                 c_rty_w   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [c_rty_w-1:0] c_rty_max = c_rty_w'(RETRY_MAX);

  localparam logic [1:0] c_st_ok  = 2'b00;
  localparam logic [1:0] c_st_err = 2'b01;
  localparam logic [1:0] c_st_rty = 2'b10;
  localparam logic [1:0] c_st_tmo = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic                  r_cyc,        w_cyc_nxt;
  logic                  r_stb,        w_stb_nxt;
  logic                  r_we,         w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_adr,        w_adr_nxt;
  logic [3:0]            r_sel,        w_sel_nxt;
  logic [31:0]           r_dat,        w_dat_nxt;
  logic                  r_rsp_valid,  w_rsp_valid_nxt;
  logic [31:0]           r_rsp_dat,    w_rsp_dat_nxt;
  logic [1:0]            r_rsp_status, w_rsp_status_nxt;
  logic [c_rty_w-1:0]    r_rty_cnt,    w_rty_cnt_nxt;

  logic       w_fin;         // attempt ends this cycle, go to RSP
  logic [1:0] w_fin_status;
  logic       w_tmo_clr;     // a new attempt starts next cycle
  logic       w_tmo_hit;     // current cycle is the last one allowed

  // --------------------------------------------------------------------------
  // Optional per-attempt timeout counter
  // --------------------------------------------------------------------------
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  logic [c_tmo_w-1:0] r_tmo_cnt;

  // Counter holds the number of cycles already spent in this attempt, so
  // the TIMEOUT_CYCLES-th cycle with cyc high is the one where it equals N-1.
  assign w_tmo_hit = (r_tmo_cnt == c_tmo_last);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || w_tmo_clr) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  localparam int c_unused_tmo = TIMEOUT_CYCLES;
  logic          w_unused_tmo_clr;

  assign w_unused_tmo_clr = w_tmo_clr;
  assign w_tmo_hit        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state and next-output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_cyc_nxt        = r_cyc;
    w_stb_nxt        = r_stb;
    w_we_nxt         = r_we;
    w_adr_nxt        = r_adr;
    w_sel_nxt        = r_sel;
    w_dat_nxt        = r_dat;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_dat_nxt    = r_rsp_dat;
    w_rsp_status_nxt = r_rsp_status;
    w_rty_cnt_nxt    = r_rty_cnt;
    w_tmo_clr        = 1'b0;
    w_fin            = 1'b0;
    w_fin_status     = c_st_ok;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_we_nxt      = cmd_we_i;
          w_adr_nxt     = cmd_adr_i;
          w_dat_nxt     = cmd_dat_i;
          w_sel_nxt     = cmd_sel_i;
          w_rty_cnt_nxt = '0;
          w_cyc_nxt     = 1'b1;
          w_stb_nxt     = 1'b1;
          w_tmo_clr     = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end

      S_REQ, S_WAIT: begin
        // While the strobe is stalled the slave has not taken the request,
        // so its response lines carry nothing for us yet.
        if (r_state == S_WAIT || !wb_stall_i) begin
          if (wb_err_i) begin
            w_fin        = 1'b1;
            w_fin_status = c_st_err;
          end else if (wb_rty_i) begin
            if (r_rty_cnt < c_rty_max) begin
              // Keep cyc asserted and re-strobe the same request.
              w_rty_cnt_nxt = r_rty_cnt + 1'b1;
              w_stb_nxt     = 1'b1;
              w_tmo_clr     = 1'b1;
              w_state_nxt   = S_REQ;
            end else begin
              w_fin        = 1'b1;
              w_fin_status = c_st_rty;
            end
          end else if (wb_ack_i) begin
            w_fin        = 1'b1;
            w_fin_status = c_st_ok;
          end else if (r_state == S_REQ) begin
            w_stb_nxt   = 1'b0;
            w_state_nxt = S_WAIT;
          end
        end

        // A termination (including a retry) on the expiry cycle wins.
        if (w_tmo_hit && !w_fin && !w_tmo_clr) begin
          w_fin        = 1'b1;
          w_fin_status = c_st_tmo;
        end

        if (w_fin) begin
          w_cyc_nxt        = 1'b0;
          w_stb_nxt        = 1'b0;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_status_nxt = w_fin_status;
          w_rsp_dat_nxt    = (w_fin_status == c_st_ok && !r_we) ? wb_dat_i : 32'h0;
          w_state_nxt      = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= 4'h0;
      r_dat        <= 32'h0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= 32'h0;
      r_rsp_status <= 2'b00;
      r_rty_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cyc        <= w_cyc_nxt;
      r_stb        <= w_stb_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_sel        <= w_sel_nxt;
      r_dat        <= w_dat_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_dat    <= w_rsp_dat_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_rty_cnt    <= w_rty_cnt_nxt;
    end
  end

  // Ready is decoded straight from the state so a command can be taken the
  // cycle after a response handshake; held low while reset is asserted.
  assign cmd_ready_o  = rst_n_i && (r_state == S_IDLE);

  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_stb;
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_sel_o     = r_sel;
  assign wb_dat_o     = r_dat;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_dat_o    = r_rsp_dat;
  assign rsp_status_o = r_rsp_status;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_master_ctrl                                               |
// | Purpose  : Self-checking bench for wb_master_ctrl: a reactive Wishbone     |
// |            slave driven per transaction, checked against a transaction-    |
// |            level model of status, data, strobe count and latency.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wb_master_ctrl;

  localparam int ADDR_WIDTH     = 32;
  localparam int RETRY_MAX      = 3;
  localparam int TIMEOUT_CYCLES = 8;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // slave termination kinds
  localparam int T_ACK = 0;
  localparam int T_ERR = 1;
  localparam int T_SIL = 2;
  localparam int T_RTY = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd_valid, cmd_ready, cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_adr;
  logic [31:0]           cmd_dat;
  logic [3:0]            cmd_sel;
  logic                  rsp_valid, rsp_ready;
  logic [31:0]           rsp_dat;
  logic [1:0]            rsp_status;
  logic                  wb_cyc, wb_stb, wb_we;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [3:0]            wb_sel;
  logic [31:0]           wb_dat_o, wb_dat_i;
  logic                  wb_ack, wb_err, wb_rty, wb_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_master_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .RETRY_MAX      (RETRY_MAX),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_adr_i    (cmd_adr),
    .cmd_dat_i    (cmd_dat),
    .cmd_sel_i    (cmd_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_status_o (rsp_status),
    .wb_cyc_o     (wb_cyc),
    .wb_stb_o     (wb_stb),
    .wb_we_o      (wb_we),
    .wb_adr_o     (wb_adr),
    .wb_sel_o     (wb_sel),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack),
    .wb_err_i     (wb_err),
    .wb_rty_i     (wb_rty),
    .wb_stall_i   (wb_stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    wb_stall = 1'b0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_rty   = 1'b0;
    wb_dat_i = $urandom;
  endtask

  // One command end to end. The slave answers every attempt after `stall`
  // stalled strobe cycles and `dly` further cycles; the first n_rty attempts
  // are answered with rty, the next with `fin`.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rdata, input int n_rty,
                         input int fin, input int stall, input int dly, input bit late_ack,
                         output int lat);
    int          cyc_total, stb_total, strobe_total, att_len, term, exp_st;
    logic [31:0] exp_dat;
    int          n, stb_hi, strobes, cyc_drop, bad_wb, bad_hold, att, stall_left, dly_left;
    bit          in_wait;
    logic [31:0] hold_dat;
    logic [1:0]  hold_st;

    // ---- reference model: walk the attempts at transaction level ----
    cyc_total = 0; stb_total = 0; strobe_total = 0; exp_st = 0;
    for (int a = 0; a <= RETRY_MAX; a++) begin
      term    = (a < n_rty) ? T_RTY : fin;
      att_len = stall + 1 + dly;
      if (TMO_EN && (term == T_SIL || att_len > TIMEOUT_CYCLES)) begin
        cyc_total += TIMEOUT_CYCLES; stb_total += stall + 1; strobe_total += 1;
        exp_st = 3;
        break;
      end
      cyc_total += att_len; stb_total += stall + 1; strobe_total += 1;
      if (term == T_RTY) begin
        exp_st = 2;
        continue;
      end
      exp_st = (term == T_ACK) ? 0 : 1;
      break;
    end
    exp_dat = (exp_st == 0 && !we) ? rdata : 32'h0;

    // ---- issue the command ----
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    check_eq("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    step();
    cmd_valid = 1'b0; cmd_we = $urandom; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);

    // ---- reactive slave until the response shows up ----
    n = 1; stb_hi = 0; strobes = 0; cyc_drop = 0; bad_wb = 0;
    att = 0; stall_left = stall; dly_left = 0; in_wait = 1'b0;
    while (!rsp_valid && n <= 200) begin
      if (!wb_cyc) cyc_drop++;
      if (wb_stb) begin
        stb_hi++;
        if (wb_we !== we || wb_adr !== adr || wb_dat_o !== dat || wb_sel !== sel) bad_wb++;
      end
      slave_idle();
      if (wb_stb && !in_wait) begin
        if (stall_left > 0) begin
          wb_stall = 1'b1;
          stall_left--;
        end else begin
          strobes++;
          in_wait  = 1'b1;
          dly_left = dly;
        end
      end
      if (in_wait) begin
        if (dly_left == 0) begin
          term = (att < n_rty) ? T_RTY : fin;
          case (term)
            T_RTY: begin wb_rty = 1'b1; att++; in_wait = 1'b0; stall_left = stall; end
            T_ACK: begin wb_ack = 1'b1; wb_dat_i = rdata; in_wait = 1'b0; end
            T_ERR: begin wb_err = 1'b1; in_wait = 1'b0; end
            default: ;
          endcase
        end else begin
          dly_left--;
        end
      end
      step();
      n++;
    end
    lat = n;
    check_eq("rsp_valid_within_budget", rsp_valid, 1);
    if (!rsp_valid) return;

    check_eq("latency", lat, 1 + cyc_total);
    check_eq("rsp_status", rsp_status, exp_st);
    check_eq("rsp_dat", rsp_dat, exp_dat);
    check_eq("strobes_accepted", strobes, strobe_total);
    check_eq("stb_high_cycles", stb_hi, stb_total);
    check_eq("cyc_drop_in_cycle", cyc_drop, 0);
    check_eq("wb_fields_on_stb", bad_wb, 0);
    check_eq("cyc_stb_at_rsp", {wb_cyc, wb_stb}, 2'b00);

    // ---- response back-pressure, optional stray ack ----
    hold_dat = rsp_dat; hold_st = rsp_status; bad_hold = 0;
    for (int h = $urandom_range(0, 2) + (late_ack ? 2 : 0); h > 0; h--) begin
      slave_idle();
      if (late_ack) begin wb_ack = 1'b1; wb_err = 1'b1; end
      rsp_ready = 1'b0;
      step();
      if (!rsp_valid || rsp_dat !== hold_dat || rsp_status !== hold_st || wb_cyc) bad_hold++;
    end
    check_eq("rsp_hold_stable", bad_hold, 0);
    slave_idle();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("rsp_valid_after_hs", rsp_valid, 0);
    check_eq("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    int lat, seen, fin, n_rty;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    slave_idle();

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctrl", {wb_cyc, wb_stb, wb_we, rsp_valid, cmd_ready}, 5'b0);
    check_eq("reset_adr_dat", {wb_adr, wb_dat_o}, 64'h0);
    check_eq("reset_sel_sts_rdat", {wb_sel, rsp_status, rsp_dat}, 38'h0);
    rst_n = 1'b1;
    step();
    check_eq("cmd_ready_out_of_reset", cmd_ready, 1);

    // ---- directed cases ----
    run_txn(1'b1, 32'h0, 32'h2, 4'hF, 32'hDEAD_BEEF, 0, T_ACK, 0, 2, 1'b0, lat);
    check_eq("write_latency_4", lat, 4);
    run_txn(1'b0, 32'h0, 32'h0, 4'hF, 32'h2, 0, T_ACK, 2, 0, 1'b0, lat);
    run_txn(1'b0, 32'h40, 32'h0, 4'h3, 32'h1234_5678, 0, T_ACK, 0, 0, 1'b0, lat);
    check_eq("min_latency_2", lat, 2);
    run_txn(1'b0, 32'h8, 32'h0, 4'hF, 32'hA5A5_0001, 2, T_ACK, 0, 1, 1'b0, lat);
    run_txn(1'b1, 32'hC, 32'h55, 4'h1, 32'h0, 3, T_ACK, 1, 0, 1'b0, lat);
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, 32'h7777_7777, 9, T_ACK, 0, 0, 1'b0, lat);
    run_txn(1'b0, 32'h14, 32'h0, 4'hF, 32'h1111_2222, 1, T_ERR, 0, 3, 1'b0, lat);
`ifdef WB_MASTER_TIMEOUT_EN
    run_txn(1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 0, T_SIL, 0, 0, 1'b1, lat);
    check_eq("timeout_latency", lat, TIMEOUT_CYCLES + 1);
    run_txn(1'b0, 32'h24, 32'h0, 4'hF, 32'hBEEF_0024, 0, T_ACK, 3, 4, 1'b0, lat);
    run_txn(1'b1, 32'h28, 32'h9, 4'hF, 32'h0, 2, T_SIL, 1, 2, 1'b0, lat);
`else
    run_txn(1'b0, 32'h24, 32'h0, 4'hF, 32'hBEEF_0024, 0, T_ACK, 6, 20, 1'b0, lat);
`endif

    // ---- randomized traffic ----
    for (int i = 0; i < 40; i++) begin
      n_rty = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
      if (TMO_EN && $urandom_range(0, 5) == 0) fin = T_SIL;
      else fin = ($urandom_range(0, 3) == 0) ? T_ERR : T_ACK;
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, n_rty, fin,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              1'($urandom), lat);
    end

    // ---- reset while waiting for the slave ----
    slave_idle();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h1234_5678; cmd_dat = 32'hCAFE_F00D; cmd_sel = 4'h5;
    step();
    cmd_valid = 1'b0;
    step();
    check_eq("in_wait_before_reset", {wb_cyc, wb_stb}, 2'b10);
    rst_n = 1'b0;
    step();
    check_eq("mid_reset_ctrl", {wb_cyc, wb_stb, wb_we, rsp_valid, cmd_ready}, 5'b0);
    check_eq("mid_reset_adr_dat", {wb_adr, wb_dat_o}, 64'h0);
    check_eq("mid_reset_sel", wb_sel, 4'h0);
    rst_n = 1'b1;
    step();
    check_eq("cmd_ready_after_reset", cmd_ready, 1);
    seen = 0;
    repeat (6) begin
      if (rsp_valid || wb_cyc) seen++;
      step();
    end
    check_eq("no_rsp_after_reset", seen, 0);

    // the master is usable again
    run_txn(1'b0, 32'h30, 32'h0, 4'hF, 32'h0BAD_F00D, 0, T_ACK, 1, 1, 1'b0, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
